// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the radix-2 Booth multiplier.
// The state encoding is also exported on a debug port.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width for a given operand width (width >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mult_booth_if.sv
// Start/result bundle between the control unit (master) and the multiplier (slave).
interface mult_booth_if #(
  parameter int WIDTH = 32
);

  // Handshake: mult_start is sampled only while the multiplier is idle
  // (mult_busy=0); op_a/op_b are captured on that same edge. mult_done is a
  // single-cycle pulse, and hi_out/lo_out hold the product from that cycle
  // until the next completion or reset. Starts while busy are dropped.
  logic             mult_start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mult_busy;
  logic             mult_done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output mult_start, op_a, op_b,
    input  mult_busy, mult_done, hi_out, lo_out
  );

  modport slave (
    input  mult_start, op_a, op_b,
    output mult_busy, mult_done, hi_out, lo_out
  );

endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,Q_-1}.
module mult_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], q_m1_i})
      2'b01:   sum = a_i + m_i;
      2'b10:   sum = a_i - m_i;
      default: sum = a_i;
    endcase
  end

  // A is one bit wider than the operands so -M never overflows.
  assign a_o    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o    = {sum[0], q_i[WIDTH-1:1]};
  assign q_m1_o = q_i[0];

endmodule

// File: rtl/mult_booth.sv
// Multicycle signed WIDTH x WIDTH multiplier (radix-2 Booth) for MULT.
// Product lands in registered HI/LO on the cycle mult_done pulses.
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mult_booth_if.slave  bus,
  output state_e       dbg_state_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic             q_m1_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   a_d;
  logic [WIDTH-1:0] q_d;
  logic             q_m1_d;

  mult_booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (q_m1_q),
    .m_i    (m_q),
    .a_o    (a_d),
    .q_o    (q_d),
    .q_m1_o (q_m1_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.mult_start) begin
            m_q     <= {bus.op_a[WIDTH-1], bus.op_a};
            a_q     <= '0;
            q_q     <= bus.op_b;
            q_m1_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_d;
          q_q    <= q_d;
          q_m1_q <= q_m1_d;
          cnt_q  <= cnt_q + CW'(1);
          // The final step's shifted result is the product; capture it
          // directly so HI/LO are valid in the DONE cycle.
          if (cnt_q == LAST_CNT) begin
            hi_q    <= a_d[WIDTH-1:0];
            lo_q    <= q_d;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mult_busy = busy_q;
  assign bus.mult_done = done_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mult_booth.sv
// Directed and random-pair bench for mult_booth (WIDTH=32).
module tb_mult_booth;
  import mult_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     checks;
  int     failures;

  mult_booth_if #(.WIDTH(W)) bus ();

  mult_booth #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Starts one multiply, scrambles the operand buses after the start edge,
  // then watches 40 cycles. lat is the cycle index of the first done pulse,
  // counting the cycle that begins at the start edge as cycle 1.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output int lat, output int busy_cnt,
                         output int done_cnt, output int hl_changes);
    logic [W-1:0] hi0, lo0;
    @(negedge clk);
    bus.op_a = a;
    bus.op_b = b;
    bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    busy_cnt = bus.mult_busy ? 1 : 0;
    hi0 = bus.hi_out;
    lo0 = bus.lo_out;
    lat = -1; done_cnt = 0; hl_changes = 0;
    hi = '0; lo = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.mult_busy) busy_cnt++;
      if (lat < 0 && (bus.hi_out !== hi0 || bus.lo_out !== lo0) && !bus.mult_done)
        hl_changes++;
      if (bus.mult_done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i + 1;
          hi = bus.hi_out;
          lo = bus.lo_out;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mult_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.mult_busy !== 1'b0 || bus.mult_done !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b state=%0d exp busy=0 done=0 state=0",
               bus.mult_busy, bus.mult_done, dbg_state);
    end
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.hi_out, bus.lo_out);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] hi, lo;
    int lat, busy_cnt, done_cnt, hlc;
    do_mult(32'd3, 32'd5, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (lat !== 33) begin
      failures++; $display("FAIL basic_latency got=%0d exp=33", lat);
    end
    checks++;
    if (busy_cnt !== 33) begin
      failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt);
    end
    checks++;
    if (hlc !== 0) begin
      failures++; $display("FAIL basic_hilo_during_run changes=%0d exp=0", hlc);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      failures++; $display("FAIL basic_product got=%h_%h exp=00000000_0000000f", hi, lo);
    end
  endtask

  task automatic test_signs();
    logic [W-1:0] hi, lo;
    int lat, busy_cnt, done_cnt, hlc;
    do_mult(32'hFFFFFFFF, 32'd1, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL neg1_x_1 got=%h_%h exp=ffffffff_ffffffff", hi, lo);
    end
    do_mult(32'hFFFFFFF9, 32'hFFFFFFFA, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000002A) begin
      failures++; $display("FAIL neg7_x_neg6 got=%h_%h exp=00000000_0000002a", hi, lo);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] hi, lo;
    int lat, busy_cnt, done_cnt, hlc;
    do_mult(32'h80000000, 32'h80000000, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
      failures++; $display("FAIL min_x_min got=%h_%h exp=40000000_00000000", hi, lo);
    end
    do_mult(32'h7FFFFFFF, 32'h7FFFFFFF, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (hi !== 32'h3FFFFFFF || lo !== 32'h00000001) begin
      failures++; $display("FAIL max_x_max got=%h_%h exp=3fffffff_00000001", hi, lo);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] hi, lo;
    int lat, done_cnt;
    @(negedge clk);
    bus.op_a = 32'd3;
    bus.op_b = 32'd5;
    bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    lat = -1; done_cnt = 0; hi = '0; lo = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (bus.mult_done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = i + 1; hi = bus.hi_out; lo = bus.lo_out;
        end
      end
      if (i == 9) begin
        bus.mult_start = 1'b1;
        bus.op_a = 32'd9;
        bus.op_b = 32'd9;
      end
      if (i == 10) bus.mult_start = 1'b0;
    end
    checks++;
    if (done_cnt !== 1 || lat !== 33) begin
      failures++;
      $display("FAIL ignore_start_pulses got=%0d@%0d exp=1@33", done_cnt, lat);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      failures++; $display("FAIL ignore_start_product got=%h_%h exp=00000000_0000000f", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] hi, lo;
    int lat, busy_cnt, done_cnt, hlc, dones;
    @(negedge clk);
    bus.op_a = 32'd3;
    bus.op_b = 32'd5;
    bus.mult_start = 1'b1;
    @(posedge clk); #1;
    bus.mult_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.mult_busy !== 1'b0 || bus.mult_done !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_ctrl busy=%b done=%b state=%0d exp busy=0 done=0 state=0",
               bus.mult_busy, bus.mult_done, dbg_state);
    end
    checks++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin
      failures++; $display("FAIL reset_mid_hilo got=%h_%h exp=0_0", bus.hi_out, bus.lo_out);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.mult_done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", dones);
    end
    do_mult(32'd2, 32'd4, hi, lo, lat, busy_cnt, done_cnt, hlc);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h8 || lat !== 33) begin
      failures++; $display("FAIL after_reset_2x4 got=%h_%h@%0d exp=00000000_00000008@33", hi, lo, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] a, b;
    logic [2*W-1:0] exp_p, got_p;
    longint prod;
    int waited;
    bit seen;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom;
      if (n == 0) begin a = 32'h80000000; b = 32'h7FFFFFFF; end
      if (n == 1) begin a = 32'h7FFFFFFF; b = 32'h80000000; end
      prod  = longint'(a) * longint'(b);
      exp_p = prod;
      // Start is driven right after the previous DONE cycle ends.
      bus.op_a = a;
      bus.op_b = b;
      bus.mult_start = 1'b1;
      @(posedge clk); #1;
      bus.mult_start = 1'b0;
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      seen = 1'b0;
      waited = 0;
      while (!seen && waited < 40) begin
        @(posedge clk); #1;
        waited++;
        if (bus.mult_done) seen = 1'b1;
      end
      got_p = {bus.hi_out, bus.lo_out};
      checks++;
      if (!seen || got_p !== exp_p) begin
        failures++;
        $display("FAIL rand_product[%0d] a=%h b=%h got=%h exp=%h seen=%0d",
                 n, a, b, got_p, exp_p, seen);
      end
      if (!seen) break;
      @(posedge clk); #1;
      checks++;
      if ({bus.hi_out, bus.lo_out} !== exp_p || bus.mult_busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_hold[%0d] got=%h busy=%b exp=%h busy=0",
                 n, {bus.hi_out, bus.lo_out}, bus.mult_busy, exp_p);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.mult_start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_ignore_start();
    test_reset_mid();
    @(negedge clk); #1;
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
